// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/control types and memory-stage state encoding
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_byte;
        logic mem_indirect;
    } lc3b_control;

    localparam int CONTROL_WIDTH = $bits(lc3b_control);

    typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} mem_state_t;

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-cache request/response port between memory stage and cache
interface mem_stage_ctrl_if;
    import lc3b_types::*;

    logic       dmem_read;
    logic       dmem_write;
    lc3b_word   dmem_address;
    lc3b_word   dmem_wdata;
    logic [1:0] dmem_byte_en;
    logic       dmem_resp;
    lc3b_word   dmem_rdata;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en,
        input  dmem_resp, dmem_rdata
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en,
        output dmem_resp, dmem_rdata
    );
endinterface

// File: rtl/mem_byte_align.sv
// rtl/mem_byte_align.sv - byte-lane select/sign-extend for loads, lane replication and byte enables for stores
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       is_byte_i,
    input  logic       addr_lsb_i,
    input  lc3b_word   rdata_i,
    input  lc3b_word   sr_i,
    output lc3b_word   load_data_o,
    output lc3b_word   store_data_o,
    output logic [1:0] byte_en_o
);
    logic [7:0] lane;

    assign lane         = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
    assign load_data_o  = is_byte_i ? {{8{lane[7]}}, lane} : rdata_i;
    assign store_data_o = is_byte_i ? {sr_i[7:0], sr_i[7:0]} : sr_i;
    assign byte_en_o    = is_byte_i ? (addr_lsb_i ? 2'b10 : 2'b01) : 2'b11;
endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - EX/MEM consumer: runs direct and indirect data-memory accesses, stalls until done
// Optional stall-cycle counter enabled by defining MEM_STAGE_PERF_EN.
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int PERF_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  lc3b_word                  exmem_ir,
    input  lc3b_word                  exmem_alu,
    input  lc3b_control               exmem_cw,
    input  lc3b_word                  exmem_sr,
    input  logic                      pipe_advance,
    mem_stage_ctrl_if.master          dmem,
    output logic                      stall,
    output lc3b_word                  mem_data,
    output logic [PERF_CNT_WIDTH-1:0] stall_count
);
    mem_state_t state_q;
    lc3b_word   ptr_q, addr_q, wdata_q, mem_data_q;
    logic       read_q, write_q;
    logic [1:0] be_q;

    logic       rd, wr, op;
    lc3b_word   ptr_src, data_addr, al_load, al_store;
    logic [1:0] al_be;
    logic       unused_ir;

    // Read wins when both read and write are set.
    assign rd = exmem_cw.mem_read;
    assign wr = exmem_cw.mem_write & ~exmem_cw.mem_read;
    assign op = rd | wr;
    assign unused_ir = ^exmem_ir;

    // While the pointer read completes, its data is forwarded so the data access issues next edge.
    assign ptr_src   = (state_q == PTR) ? word_align(dmem.dmem_rdata) : ptr_q;
    assign data_addr = exmem_cw.mem_indirect ? ptr_src :
                       (exmem_cw.mem_byte ? exmem_alu : word_align(exmem_alu));

    mem_byte_align u_align (
        .is_byte_i    (exmem_cw.mem_byte),
        .addr_lsb_i   (data_addr[0]),
        .rdata_i      (dmem.dmem_rdata),
        .sr_i         (exmem_sr),
        .load_data_o  (al_load),
        .store_data_o (al_store),
        .byte_en_o    (al_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            mem_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (op) begin
                    if (exmem_cw.mem_indirect) begin
                        state_q <= PTR;
                        read_q  <= 1'b1;
                        addr_q  <= word_align(exmem_alu);
                    end else begin
                        state_q <= DATA;
                        read_q  <= rd;
                        write_q <= wr;
                        addr_q  <= data_addr;
                        wdata_q <= wr ? al_store : '0;
                        be_q    <= wr ? al_be : '0;
                    end
                end
                PTR: if (dmem.dmem_resp) begin
                    ptr_q   <= word_align(dmem.dmem_rdata);
                    state_q <= DATA;
                    read_q  <= rd;
                    write_q <= wr;
                    addr_q  <= data_addr;
                    wdata_q <= wr ? al_store : '0;
                    be_q    <= wr ? al_be : '0;
                end
                DATA: if (dmem.dmem_resp) begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (rd) mem_data_q <= al_load;
                    state_q <= DONE;
                end
                DONE: if (pipe_advance) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign dmem.dmem_byte_en = be_q;
    assign mem_data          = mem_data_q;

    // Gated by rst_n so the IDLE decode term cannot raise stall while reset is held.
    assign stall = rst_n & (((state_q == IDLE) & op) | (state_q == PTR) | (state_q == DATA));

`ifdef MEM_STAGE_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall && (cnt_q != '1))
            cnt_q <= cnt_q + PERF_CNT_WIDTH'(1);
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl: vector table, random ops, reset abort
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    typedef struct {
        lc3b_control cw;
        lc3b_word    alu, sr, r0, r1;
        int          k0, k1;
    } stim_t;

    typedef struct {
        int         n;
        lc3b_word   addr0, addr1, wdata, mem;
        logic       wr;
        logic [1:0] be;
        int         stall;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk, rst_n, pipe_advance;
    lc3b_word    exmem_ir, exmem_alu, exmem_sr, mem_data;
    lc3b_control exmem_cw;
    logic        stall;
    logic [15:0] stall_count;

    int total_checks = 0;
    int pass_checks  = 0;
    int exp_total    = 0;
    lc3b_word cur_mem;

    mem_stage_ctrl_if dif ();

    mem_stage_ctrl #(.PERF_CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exmem_ir     (exmem_ir),
        .exmem_alu    (exmem_alu),
        .exmem_cw     (exmem_cw),
        .exmem_sr     (exmem_sr),
        .pipe_advance (pipe_advance),
        .dmem         (dif),
        .stall        (stall),
        .mem_data     (mem_data),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int exp_cnt();
`ifdef MEM_STAGE_PERF_EN
        return exp_total;
`else
        return 0;
`endif
    endfunction

    // Reference: what the access sequence should look like, from the ISA-level rules.
    function automatic exp_t model(input stim_t s, input lc3b_word prev);
        exp_t e;
        int alu, ptr, da, rd_word, b;
        logic is_rd, is_wr;
        is_rd = s.cw.mem_read;
        is_wr = s.cw.mem_write && !is_rd;
        alu = s.alu;
        ptr = s.r0 - (s.r0 % 2);
        da  = s.cw.mem_indirect ? ptr : (s.cw.mem_byte ? alu : alu - (alu % 2));
        e.n = (!is_rd && !is_wr) ? 0 : (s.cw.mem_indirect ? 2 : 1);
        e.addr0 = (e.n == 2) ? lc3b_word'(alu - (alu % 2)) : lc3b_word'(da);
        e.addr1 = lc3b_word'(da);
        e.wr    = is_wr;
        e.wdata = s.cw.mem_byte ? lc3b_word'((s.sr % 256) * 257) : s.sr;
        e.be    = s.cw.mem_byte ? ((da % 2) ? 2'd2 : 2'd1) : 2'd3;
        e.stall = (e.n == 0) ? 0 : 1 + (s.k0 + 1) + ((e.n == 2) ? s.k1 + 1 : 0);
        e.mem   = prev;
        if (is_rd) begin
            rd_word = (e.n == 2) ? s.r1 : s.r0;
            if (s.cw.mem_byte) begin
                b = (da % 2) ? rd_word / 256 : rd_word % 256;
                e.mem = (b >= 128) ? lc3b_word'(b + 'hFF00) : lc3b_word'(b);
            end else begin
                e.mem = lc3b_word'(rd_word);
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] cw, input lc3b_word alu, sr, r0, r1, input int k0, k1,
                                input int n, input lc3b_word a0, a1, input logic wr, input lc3b_word wd,
                                input logic [1:0] be, input lc3b_word mem, input int st);
        vec_t v;
        v.s.cw = lc3b_control'(cw); v.s.alu = alu; v.s.sr = sr; v.s.r0 = r0; v.s.r1 = r1;
        v.s.k0 = k0; v.s.k1 = k1;
        v.e.n = n; v.e.addr0 = a0; v.e.addr1 = a1; v.e.wr = wr; v.e.wdata = wd;
        v.e.be = be; v.e.mem = mem; v.e.stall = st;
        return v;
    endfunction

    // Entered and left at posedge+1; acts as the data cache with per-access latency k.
    task automatic do_op(input stim_t s, input exp_t e, input int hold);
        int idx, waited, st, cyc, lat;
        bit pend, data_acc;
        lc3b_word ea;
        idx = 0; waited = 0; st = 0; cyc = 0; pend = 0;
        exmem_cw = s.cw; exmem_alu = s.alu; exmem_sr = s.sr; exmem_ir = lc3b_word'($urandom);
        pipe_advance = 1'b0;
        while (idx < e.n && cyc < 200) begin
            dif.dmem_resp  = 1'b0;
            dif.dmem_rdata = lc3b_word'($urandom);
            if (dif.dmem_read || dif.dmem_write) begin
                data_acc = (idx == e.n - 1);
                ea  = (data_acc && e.n == 2) ? e.addr1 : e.addr0;
                lat = (idx == 0) ? s.k0 : s.k1;
                if (!pend) begin
                    pend = 1; waited = 0;
                    chk("req_addr", dif.dmem_address, ea);
                    chk("req_read", dif.dmem_read, data_acc ? !e.wr : 1'b1);
                    chk("req_write", dif.dmem_write, data_acc ? e.wr : 1'b0);
                    if (data_acc && e.wr) begin
                        chk("req_wdata", dif.dmem_wdata, e.wdata);
                        chk("req_byte_en", dif.dmem_byte_en, e.be);
                    end
                end else begin
                    waited++;
                    chk("req_hold_addr", dif.dmem_address, ea);
                end
                if (waited == lat) begin
                    dif.dmem_resp  = 1'b1;
                    dif.dmem_rdata = (idx == 0) ? s.r0 : s.r1;
                    pend = 0;
                    idx++;
                end
            end
            @(negedge clk);
            if (stall) st++;
            @(posedge clk); #1;
            cyc++;
        end
        dif.dmem_resp = 1'b0;
        chk("accesses_done", idx, e.n);
        if (e.n > 0) chk("stall_cycles", st, e.stall);
        exp_total += e.stall;
        for (int i = 0; i < hold; i++) begin
            dif.dmem_resp  = (i == 0);
            dif.dmem_rdata = lc3b_word'($urandom);
            @(negedge clk);
            chk("idle_stall", stall, 1'b0);
            chk("idle_req", {dif.dmem_read, dif.dmem_write}, 2'b00);
            chk("mem_data", mem_data, e.mem);
            @(posedge clk); #1;
        end
        dif.dmem_resp = 1'b0;
        chk("stall_count", stall_count, exp_cnt());
        pipe_advance = 1'b1;
        @(posedge clk); #1;
        pipe_advance = 1'b0;
        exmem_cw = lc3b_control'(4'b0000);
    endtask

    vec_t  tbl[10];
    stim_t rs;
    exp_t  re;

    initial begin
        rst_n = 1'b0; pipe_advance = 1'b0;
        exmem_cw = lc3b_control'(4'b0000); exmem_alu = '0; exmem_sr = '0; exmem_ir = '0;
        dif.dmem_resp = 1'b0; dif.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_req", {dif.dmem_read, dif.dmem_write}, 2'b00);
        chk("rst_addr", dif.dmem_address, 16'h0);
        chk("rst_wdata", dif.dmem_wdata, 16'h0);
        chk("rst_be", dif.dmem_byte_en, 2'b00);
        chk("rst_mem_data", mem_data, 16'h0);
        chk("rst_stall_count", stall_count, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_mem = '0;

        //             cw      alu      sr       r0       r1       k0 k1 n  addr0    addr1    wr  wdata    be     mem      stall
        tbl[0] = mk(4'b0000, 16'h3004, 16'h0,    16'h0,    16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 16'h0,    2'b00, 16'h0000, 0);
        tbl[1] = mk(4'b1000, 16'h3004, 16'h0,    16'hBEEF, 16'h0,    2, 0, 1, 16'h3004, 16'h3004, 0, 16'h0,    2'b00, 16'hBEEF, 4);
        tbl[2] = mk(4'b1010, 16'h3005, 16'h0,    16'h80AA, 16'h0,    1, 0, 1, 16'h3005, 16'h3005, 0, 16'h0,    2'b00, 16'hFF80, 3);
        tbl[3] = mk(4'b1010, 16'h3004, 16'h0,    16'h80AA, 16'h0,    0, 0, 1, 16'h3004, 16'h3004, 0, 16'h0,    2'b00, 16'hFFAA, 2);
        tbl[4] = mk(4'b0110, 16'h2001, 16'h1234, 16'h0,    16'h0,    3, 0, 1, 16'h2001, 16'h2001, 1, 16'h3434, 2'b10, 16'hFFAA, 5);
        tbl[5] = mk(4'b1001, 16'h4000, 16'h0,    16'h5003, 16'h0042, 1, 2, 2, 16'h4000, 16'h5002, 0, 16'h0,    2'b00, 16'h0042, 6);
        tbl[6] = mk(4'b0100, 16'h2223, 16'hABCD, 16'h0,    16'h0,    1, 0, 1, 16'h2222, 16'h2222, 1, 16'hABCD, 2'b11, 16'h0042, 3);
        tbl[7] = mk(4'b1100, 16'h1000, 16'h9999, 16'h1111, 16'h0,    0, 0, 1, 16'h1000, 16'h1000, 0, 16'h0,    2'b00, 16'h1111, 2);
        tbl[8] = mk(4'b0101, 16'h6001, 16'h5566, 16'h7005, 16'h0,    0, 1, 2, 16'h6000, 16'h7004, 1, 16'h5566, 2'b11, 16'h1111, 4);
        tbl[9] = mk(4'b1000, 16'h3007, 16'h0,    16'h8001, 16'h0,    0, 0, 1, 16'h3006, 16'h3006, 0, 16'h0,    2'b00, 16'h8001, 2);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].s, tbl[i].e, (tbl[i].e.n == 0) ? 5 : 3);
            cur_mem = tbl[i].e.mem;
        end

        for (int i = 0; i < 40; i++) begin
            rs.cw  = lc3b_control'(4'($urandom_range(0, 15)));
            rs.alu = lc3b_word'($urandom);
            rs.sr  = lc3b_word'($urandom);
            rs.r0  = lc3b_word'($urandom);
            rs.r1  = lc3b_word'($urandom);
            rs.k0  = $urandom_range(0, 3);
            rs.k1  = $urandom_range(0, 3);
            re = model(rs, cur_mem);
            do_op(rs, re, $urandom_range(1, 3));
            cur_mem = re.mem;
        end

        // Reset while the data read is outstanding.
        exmem_cw = lc3b_control'(4'b1000); exmem_alu = 16'h3004;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pre_read", dif.dmem_read, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_read", dif.dmem_read, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_stall_count", stall_count, 16'h0);
        @(posedge clk); #1;
        exmem_cw = lc3b_control'(4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_stall", stall, 1'b0);
        chk("post_abort_req", {dif.dmem_read, dif.dmem_write}, 2'b00);
        chk("post_abort_mem_data", mem_data, 16'h0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end
endmodule
